// File: rtl/d7s_entry.sv
// d7s_entry: decodes up to three active-low 7-segment digit codes (MSD first) into an 8-bit value
// Ports: clk, reset (sync, active-high); seg_in/seg_valid/seg_ready digit input handshake;
//   enter finishes a value early; value/ovf/err/out_valid/out_ready result handshake.
// Option: define D7S_ENTRY_BLANK_EN to accept 7F as a leading blank (digit 0) while acc is zero.
module d7s_entry (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_in,
  input  logic       seg_valid,
  output logic       seg_ready,
  input  logic       enter,
  output logic [7:0] value,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       ovf,
  output logic       err
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  logic [1:0] state;
  logic [9:0] acc, acc_nx;
  logic [1:0] cnt, cnt_nx;
  logic [3:0] dig;
  logic       dig_ok, take, good, fin;
  always_comb begin
    dig    = 4'd0;
    dig_ok = 1'b1;
    case (seg_in)
      7'h40: dig = 4'd0;
      7'h79: dig = 4'd1;
      7'h24: dig = 4'd2;
      7'h30: dig = 4'd3;
      7'h19: dig = 4'd4;
      7'h12: dig = 4'd5;
      7'h02: dig = 4'd6;
      7'h78: dig = 4'd7;
      7'h00: dig = 4'd8;
      7'h10: dig = 4'd9;
`ifdef D7S_ENTRY_BLANK_EN
      7'h7f: dig_ok = (acc == 10'd0);
`endif
      default: dig_ok = 1'b0;
    endcase
  end
  assign seg_ready = !reset && state != DONE;
  assign out_valid = state == DONE;
  assign take      = seg_valid && seg_ready;
  assign good      = take && dig_ok;
  // acc never exceeds 99 before a digit lands, so the sum fits in 10 bits
  assign acc_nx    = good ? acc * 10'd10 + {6'd0, dig} : acc;
  assign cnt_nx    = cnt + {1'b0, good};
  // a digit arriving with enter is folded in before finalizing
  assign fin       = (state == ACCUM && enter) || cnt_nx == 2'd3;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= 10'd0;
      cnt   <= 2'd0;
      err   <= 1'b0;
      ovf   <= 1'b0;
      value <= 8'd0;
    end else if (state == DONE) begin
      if (out_ready) begin
        state <= IDLE;
        acc   <= 10'd0;
        cnt   <= 2'd0;
        err   <= 1'b0;
        ovf   <= 1'b0;
      end
    end else begin
      acc <= acc_nx;
      cnt <= cnt_nx;
      if (take && !dig_ok) err <= 1'b1;
      if (fin) begin
        state <= DONE;
        value <= acc_nx > 10'd255 ? 8'hff : acc_nx[7:0];
        ovf   <= acc_nx > 10'd255;
      end else if (good) state <= ACCUM;
    end
  end
endmodule
